quad_enc_tx: RTL

//  Quadrature encoder transmitter: the output-side counterpart of quad_enc. Converts signed edge-count

---
 rtl/quad_enc_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/quad_enc_tx.sv
// Quadrature encoder transmitter: turns signed edge-count commands into A/B quadrature at a programmable spacing.
// Optional index output (enc_z) and revolution counter enabled by defining QUAD_ENC_TX_INDEX_EN.
module quad_enc_tx #(
   parameter int CMDW    = 16,
   parameter int PERIODW = 16,
   parameter int POSW    = 32
`ifdef QUAD_ENC_TX_INDEX_EN
  ,parameter int CPR     = 4096
`endif
) (
   input  logic               CLK,
   input  logic               resetn,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CMDW-1:0]    cmd_count,
   input  logic [PERIODW-1:0] config_period,
   input  logic               abort,
   output logic               enc_a,
   output logic               enc_b,
   output logic               busy,
   output logic               done,
   output logic [POSW-1:0]    position
`ifdef QUAD_ENC_TX_INDEX_EN
  ,output logic               enc_z
`endif
);

   localparam logic [CMDW:0]      REM_ONE = 1;
   localparam logic [PERIODW-1:0] PER_ONE = 1;
   localparam logic [POSW-1:0]    POS_ONE = 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_accept;
   logic                 w_emit;
   logic                 w_done_nxt;
   logic                 w_cmd_zero;
   logic [CMDW:0]        w_cmd_abs;
   logic [PERIODW-1:0]   w_per;
   logic [1:0]           w_phase_nxt;

   logic                 r_dir;
   logic [CMDW:0]        r_remaining;
   logic [PERIODW-1:0]   r_per;
   logic [PERIODW-1:0]   r_timer;
   logic [1:0]           r_phase;
   logic                 r_enc_a;
   logic                 r_enc_b;
   logic                 r_done;
   logic [POSW-1:0]      r_position;

   // Magnitude is one bit wider so the most negative command is representable.
   assign w_cmd_zero  = (cmd_count == '0);
   assign w_cmd_abs   = cmd_count[CMDW-1] ? ({1'b0, ~cmd_count} + REM_ONE) : {1'b0, cmd_count};
   assign w_per       = (config_period == '0) ? PER_ONE : config_period;
   assign w_phase_nxt = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_emit      = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               if (w_cmd_zero) w_done_nxt  = 1'b1;
               else            w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // abort takes priority over a timer expiry in the same cycle
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else if (r_timer == PER_ONE) begin
               w_emit = 1'b1;
               if (r_remaining == REM_ONE) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_dir       <= 1'b0;
         r_remaining <= '0;
         r_per       <= PER_ONE;
         r_timer     <= PER_ONE;
         r_phase     <= '0;
         r_enc_a     <= 1'b0;
         r_enc_b     <= 1'b0;
         r_done      <= 1'b0;
         r_position  <= '0;
      end else begin
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_dir       <= cmd_count[CMDW-1];
            r_remaining <= w_cmd_abs;
            r_per       <= w_per;
            r_timer     <= w_per;
         end else if (w_emit) begin
            r_timer     <= r_per;
            r_remaining <= r_remaining - REM_ONE;
            r_phase     <= w_phase_nxt;
            r_enc_a     <= w_phase_nxt[1] ^ w_phase_nxt[0];
            r_enc_b     <= w_phase_nxt[1];
            r_position  <= r_dir ? (r_position - POS_ONE) : (r_position + POS_ONE);
         end else if (r_state == S_RUN && !abort) begin
            r_timer <= r_timer - PER_ONE;
         end
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN);
   assign done      = r_done;
   assign enc_a     = r_enc_a;
   assign enc_b     = r_enc_b;
   assign position  = r_position;

`ifdef QUAD_ENC_TX_INDEX_EN
   localparam int REVW = (CPR > 1) ? $clog2(CPR) : 1;
   localparam logic [REVW-1:0] REV_MAX = REVW'(CPR - 1);
   localparam logic [REVW-1:0] REV_ONE = 1;

   logic [REVW-1:0] r_rev;
   logic [REVW-1:0] w_rev_nxt;
   logic            r_enc_z;

   always_comb begin
      w_rev_nxt = r_rev;
      if (r_dir) w_rev_nxt = (r_rev == '0)     ? REV_MAX : (r_rev - REV_ONE);
      else       w_rev_nxt = (r_rev == REV_MAX) ? '0      : (r_rev + REV_ONE);
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_rev   <= '0;
         r_enc_z <= 1'b1;
      end else if (w_emit) begin
         r_rev   <= w_rev_nxt;
         r_enc_z <= (w_rev_nxt == '0);
      end
   end

   assign enc_z = r_enc_z;
`endif

endmodule
